// File: rtl/psum_accum_ctrl_pkg.sv
// Shared definitions for the partial-sum accumulation path: FSM state
// encoding, buffer geometry helpers and the saturating-add overflow decision.
package psum_accum_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_kind_e;

    // Number of OFM pixels in one square output map.
    function automatic int ofm_pixels(input int ofm_size);
        return ofm_size * ofm_size;
    endfunction

    // Address width needed to index every pixel of the accumulation buffer.
    function automatic int buf_addr_width(input int ofm_size);
        return $clog2(ofm_pixels(ofm_size));
    endfunction

    // Overflow decision for a W-bit add computed at W+1 bits. top2 holds
    // bits [W:W-1] of the wide sum; the add overflowed when they differ,
    // and bit W tells the true sign of the result.
    function automatic sat_kind_e sat_classify(input logic [1:0] top2);
        sat_kind_e kind;
        case (top2)
            2'b01:   kind = SAT_POS;
            2'b10:   kind = SAT_NEG;
            default: kind = SAT_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/psum_accum_ctrl_sat_add.sv
// Combinational psum adder: passes b through on the first channel, otherwise
// adds a+b and clamps the result to the signed W-bit range.
module psum_sat_add
    import psum_accum_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                first,
    output logic signed [W-1:0] sum,
    output logic                sat
);

    logic [W:0] wide;

    assign wide = {a[W-1], a} + {b[W-1], b};

    // Select passthrough, clamped or plain sum and flag any clamp.
    always_comb begin
        sum = b;
        sat = 1'b0;
        if (!first) begin
            case (sat_classify(wide[W:W-1]))
                SAT_POS: begin
                    sum = {1'b0, {(W-1){1'b1}}};
                    sat = 1'b1;
                end
                SAT_NEG: begin
                    sum = {1'b1, {(W-1){1'b0}}};
                    sat = 1'b1;
                end
                default: sum = wide[W-1:0];
            endcase
        end
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulation sequencer for one convolution layer pass.
// Channel 0 stores psums, middle channels read-add-write the buffer, and
// the last channel emits finished OFM pixels instead of writing back.
// Valid/ready note: there is no backpressure anywhere; psum_vld is a pure
// valid, and buf_wr_en / ofm_vld are single-cycle valids the consumers must
// take. buf_rd_data is expected one cycle after buf_rd_en.
module psum_accum_ctrl
    import psum_accum_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CHANNEL = 3,
    parameter int OFM_SIZE    = 7,
    parameter int RELU        = 1,
    parameter int AW          = buf_addr_width(OFM_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         psum_vld,
    input  logic signed [DATA_WIDTH-1:0] psum_in,
    output logic                         buf_rd_en,
    output logic        [AW-1:0]         buf_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] buf_rd_data,
    output logic                         buf_wr_en,
    output logic        [AW-1:0]         buf_wr_addr,
    output logic        [DATA_WIDTH-1:0] buf_wr_data,
    output logic                         ofm_vld,
    output logic        [DATA_WIDTH-1:0] ofm_data,
    output logic                         busy,
    output logic                         done,
    output logic                         sat_flag
);

    localparam int N  = ofm_pixels(OFM_SIZE);
    localparam int CW = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
    localparam logic [AW-1:0] PIX_LAST = AW'(N - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CHANNEL - 1);

    state_e state;
    state_e state_nxt;

    logic [AW-1:0] pix_cnt;
    logic [CW-1:0] ch_cnt;

    logic accept;
    logic start_ok;
    logic pix_wrap;
    logic ch_first;
    logic ch_last;
    logic final_psum;

    // Stage-1 register: one accepted psum waiting for its buffer read data.
    logic                         s1_vld;
    logic        [AW-1:0]         s1_addr;
    logic signed [DATA_WIDTH-1:0] s1_psum;
    logic                         s1_first;
    logic                         s1_last;
    logic signed [DATA_WIDTH-1:0] s1_sum;
    logic                         s1_sat;

    assign accept     = (state == ACCUM) && psum_vld;
    assign start_ok   = (state == IDLE) && start;
    assign pix_wrap   = (pix_cnt == PIX_LAST);
    assign ch_first   = (ch_cnt == '0);
    assign ch_last    = (ch_cnt == CH_LAST);
    assign final_psum = accept && pix_wrap && ch_last;

    // Stage 0: fetch the running sum for every channel after the first.
    assign buf_rd_en   = accept && !ch_first;
    assign buf_rd_addr = pix_cnt;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (final_psum) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy spans ACCUM..DONE, done marks the DONE cycle.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Pixel and channel counters; both wrap to zero after the final psum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt <= '0;
            ch_cnt  <= '0;
        end else if (start_ok) begin
            pix_cnt <= '0;
            ch_cnt  <= '0;
        end else if (accept) begin
            if (pix_wrap) begin
                pix_cnt <= '0;
                ch_cnt  <= ch_last ? '0 : ch_cnt + CW'(1);
            end else begin
                pix_cnt <= pix_cnt + AW'(1);
            end
        end
    end

    // Capture the accepted psum and its channel role into stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_addr  <= '0;
            s1_psum  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_addr  <= pix_cnt;
                s1_psum  <= psum_in;
                s1_first <= ch_first;
                s1_last  <= ch_last;
            end
        end
    end

    psum_sat_add #(
        .W(DATA_WIDTH)
    ) u_sat_add (
        .a    (buf_rd_data),
        .b    (s1_psum),
        .first(s1_first),
        .sum  (s1_sum),
        .sat  (s1_sat)
    );

    // Sticky saturation flag, cleared when a new pass is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (start_ok) begin
            sat_flag <= 1'b0;
        end else if (s1_vld && s1_sat) begin
            sat_flag <= 1'b1;
        end
    end

    // Stage 1: write back the running sum, or emit the finished pixel.
    always_comb begin
        buf_wr_en   = 1'b0;
        buf_wr_addr = '0;
        buf_wr_data = '0;
        ofm_vld     = 1'b0;
        ofm_data    = '0;
        if (s1_vld) begin
            if (s1_last) begin
                ofm_vld  = 1'b1;
                ofm_data = ((RELU != 0) && s1_sum[DATA_WIDTH-1]) ? '0 : s1_sum;
            end else begin
                buf_wr_en   = 1'b1;
                buf_wr_addr = s1_addr;
                buf_wr_data = s1_sum;
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Bench for psum_accum_ctrl: a default 3-channel 7x7 RELU instance with a
// behavioural buffer RAM, and a 1-channel 2x2 non-RELU instance.
module tb_psum_accum_ctrl;

    localparam int DW   = 16;
    localparam int NC   = 3;
    localparam int N    = 49;
    localparam int AW   = 6;
    localparam int AW2  = 2;
    localparam int SMAX = (1 << (DW - 1)) - 1;
    localparam int SMIN = -(1 << (DW - 1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1 (defaults) ----------------
    logic          start, psum_vld;
    logic [DW-1:0] psum_in;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [DW-1:0] buf_rd_data = '0;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [DW-1:0] buf_wr_data;
    logic          ofm_vld;
    logic [DW-1:0] ofm_data;
    logic          busy, done, sat_flag;

    psum_accum_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .psum_vld   (psum_vld),
        .psum_in    (psum_in),
        .buf_rd_en  (buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .buf_rd_data(buf_rd_data),
        .buf_wr_en  (buf_wr_en),
        .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data),
        .ofm_vld    (ofm_vld),
        .ofm_data   (ofm_data),
        .busy       (busy),
        .done       (done),
        .sat_flag   (sat_flag)
    );

    // Buffer RAM: read data one cycle after the request.
    logic [DW-1:0] mem [64];

    always @(posedge clk) begin
        if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    // ---------------- DUT 2 (1 channel, 2x2, no RELU) ----------------
    logic           start2, psum_vld2;
    logic [DW-1:0]  psum_in2;
    logic           buf_rd_en2;
    logic [AW2-1:0] buf_rd_addr2;
    logic [DW-1:0]  buf_rd_data2 = 16'h1234;
    logic           buf_wr_en2;
    logic [AW2-1:0] buf_wr_addr2;
    logic [DW-1:0]  buf_wr_data2;
    logic           ofm_vld2;
    logic [DW-1:0]  ofm_data2;
    logic           busy2, done2, sat_flag2;

    psum_accum_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_CHANNEL(1),
        .OFM_SIZE   (2),
        .RELU       (0)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .psum_vld   (psum_vld2),
        .psum_in    (psum_in2),
        .buf_rd_en  (buf_rd_en2),
        .buf_rd_addr(buf_rd_addr2),
        .buf_rd_data(buf_rd_data2),
        .buf_wr_en  (buf_wr_en2),
        .buf_wr_addr(buf_wr_addr2),
        .buf_wr_data(buf_wr_data2),
        .ofm_vld    (ofm_vld2),
        .ofm_data   (ofm_data2),
        .busy       (busy2),
        .done       (done2),
        .sat_flag   (sat_flag2)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rd_q[$];   // {cycle, addr}
    logic [47:0] exp_wr_q[$];   // {cycle, addr, data}
    logic [39:0] exp_ofm_q[$];  // {cycle, data}
    logic [39:0] exp_ofm2_q[$]; // {cycle, data}
    int          exp_done_cyc  = -1;
    int          exp_done2_cyc = -1;

    // Reference model: running per-pixel sum with saturation after each add.
    int acc [N];

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic [31:0] mon_rd;
    logic [47:0] mon_wr;
    logic [39:0] mon_ofm;

    always @(negedge clk) begin
        if (buf_rd_en) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got addr=%0d cyc=%0d exp none", buf_rd_addr, cyc);
            end else begin
                mon_rd = exp_rd_q.pop_front();
                if (mon_rd !== {24'(cyc), 8'(buf_rd_addr)}) begin
                    errors++;
                    $display("FAIL rd got cyc=%0d addr=%0d exp cyc=%0d addr=%0d",
                             cyc, buf_rd_addr, mon_rd[31:8], mon_rd[7:0]);
                end
            end
        end
        if (buf_wr_en) begin
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got addr=%0d data=%h exp none", buf_wr_addr, buf_wr_data);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                if (mon_wr !== {24'(cyc), 8'(buf_wr_addr), buf_wr_data}) begin
                    errors++;
                    $display("FAIL wr got cyc=%0d addr=%0d data=%h exp cyc=%0d addr=%0d data=%h",
                             cyc, buf_wr_addr, buf_wr_data, mon_wr[47:24], mon_wr[23:16], mon_wr[15:0]);
                end
            end
        end
        if (ofm_vld) begin
            checks++;
            if (exp_ofm_q.size() == 0) begin
                errors++;
                $display("FAIL ofm_unexpected got data=%h exp none", ofm_data);
            end else begin
                mon_ofm = exp_ofm_q.pop_front();
                if (mon_ofm !== {24'(cyc), ofm_data}) begin
                    errors++;
                    $display("FAIL ofm got cyc=%0d data=%h exp cyc=%0d data=%h",
                             cyc, ofm_data, mon_ofm[39:16], mon_ofm[15:0]);
                end
            end
        end
        if (done) begin
            checks++;
            if (cyc != exp_done_cyc || !busy) begin
                errors++;
                $display("FAIL done_timing got cyc=%0d busy=%0b exp cyc=%0d busy=1", cyc, busy, exp_done_cyc);
            end
            exp_done_cyc = -1;
        end
    end

    always @(negedge clk) begin
        if (busy2) begin
            checks++;
            if (buf_rd_en2 || buf_wr_en2) begin
                errors++;
                $display("FAIL nc1_buf_access got rd=%0b wr=%0b exp rd=0 wr=0", buf_rd_en2, buf_wr_en2);
            end
        end
        if (ofm_vld2) begin
            checks++;
            if (exp_ofm2_q.size() == 0) begin
                errors++;
                $display("FAIL ofm2_unexpected got data=%h exp none", ofm_data2);
            end else begin
                mon_ofm = exp_ofm2_q.pop_front();
                if (mon_ofm !== {24'(cyc), ofm_data2}) begin
                    errors++;
                    $display("FAIL ofm2 got cyc=%0d data=%h exp cyc=%0d data=%h",
                             cyc, ofm_data2, mon_ofm[39:16], mon_ofm[15:0]);
                end
            end
        end
        if (done2) begin
            checks++;
            if (cyc != exp_done2_cyc) begin
                errors++;
                $display("FAIL done2_timing got cyc=%0d exp cyc=%0d", cyc, exp_done2_cyc);
            end
            exp_done2_cyc = -1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_slot();
        @(posedge clk);
        #1;
        start    = 1'b0;
        psum_vld = 1'b0;
        psum_in  = DW'($urandom);
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start    = 1'b1;
        psum_vld = 1'b0;
        idle_slot();
        check_val("busy_after_start", 32'(busy), 32'd1);
        check_val("sat_clear_on_start", 32'(sat_flag), 32'd0);
    endtask

    function automatic logic [DW-1:0] pick_value(input int mode, input int ch);
        logic [DW-1:0] v;
        case (mode)
            0:       v = 16'd10;
            1:       v = (ch == 0) ? 16'h7FF0 : (ch == 1) ? 16'h0020 : 16'h0000;
            2:       v = (ch == 0) ? 16'hFFFB : 16'h0000;
            default: v = ($urandom_range(0, 3) == 0) ? DW'($urandom)
                                                      : DW'($urandom_range(0, 400)) - 16'd200;
        endcase
        return v;
    endfunction

    // Drive one psum this cycle and record what the DUT must do with it.
    task automatic send_psum(input int ch, input int pix, input logic [DW-1:0] v);
        int s;
        psum_vld = 1'b1;
        psum_in  = v;
        if (ch == 0) begin
            acc[pix] = int'($signed(v));
        end else begin
            s = acc[pix] + int'($signed(v));
            acc[pix] = (s > SMAX) ? SMAX : (s < SMIN) ? SMIN : s;
            exp_rd_q.push_back({24'(cyc), 8'(pix)});
        end
        if (ch != NC - 1)
            exp_wr_q.push_back({24'(cyc + 1), 8'(pix), DW'(acc[pix])});
        else
            exp_ofm_q.push_back({24'(cyc + 1), DW'((acc[pix] < 0) ? 0 : acc[pix])});
    endtask

    task automatic run_pass(input int mode);
        for (int ch = 0; ch < NC; ch++) begin
            for (int pix = 0; pix < N; pix++) begin
                if (mode == 3) begin
                    if (pix == 0 && ch > 0) repeat (3) idle_slot();
                    while ($urandom_range(0, 99) < 25) idle_slot();
                end
                @(posedge clk);
                #1;
                start = (mode == 3 && ch == 1 && pix == 10);
                send_psum(ch, pix, pick_value(mode, ch));
                if (ch == NC - 1 && pix == N - 1) exp_done_cyc = cyc + 2;
            end
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            idle_slot();
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout got done=0 exp done=1");
        end
    endtask

    // ---------------- main sequence ----------------
    logic [DW-1:0] v2;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        psum_vld  = 1'b0;
        psum_in   = '0;
        start2    = 1'b0;
        psum_vld2 = 1'b0;
        psum_in2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_buf_rd_en", 32'(buf_rd_en), 32'd0);
        check_val("rst_buf_rd_addr", 32'(buf_rd_addr), 32'd0);
        check_val("rst_buf_wr_en", 32'(buf_wr_en), 32'd0);
        check_val("rst_ofm_vld", 32'(ofm_vld), 32'd0);
        check_val("rst_ofm_data", 32'(ofm_data), 32'd0);
        check_val("rst_busy_done_sat", {29'd0, busy, done, sat_flag}, 32'd0);
        rst = 1'b0;

        // psum_vld while idle must be ignored.
        repeat (3) begin
            @(posedge clk);
            #1;
            psum_vld = 1'b1;
            psum_in  = 16'd77;
        end
        idle_slot();
        check_val("idle_busy", 32'(busy), 32'd0);

        // Constant 10s: 10, 20, 30.
        do_start();
        run_pass(0);
        wait_done();
        check_val("const_sat_flag", 32'(sat_flag), 32'd0);

        // Saturation: 0x7FF0 + 0x0020 clamps to 0x7FFF; sticky until start.
        do_start();
        run_pass(1);
        wait_done();
        check_val("sat_flag_set", 32'(sat_flag), 32'd1);
        check_val("sat_mem0", 32'(mem[0]), 32'h7FFF);
        check_val("sat_mem48", 32'(mem[48]), 32'h7FFF);
        repeat (3) idle_slot();
        check_val("sat_flag_sticky", 32'(sat_flag), 32'd1);

        // Final sum -5 with RELU clamps to 0.
        do_start();
        run_pass(2);
        wait_done();
        check_val("relu_sat_flag", 32'(sat_flag), 32'd0);

        // Random values, random gaps, boundary gaps, start while busy.
        do_start();
        run_pass(3);
        wait_done();

        // Reset during channel 1 at pixel 20.
        do_start();
        for (int pix = 0; pix < N; pix++) begin
            @(posedge clk);
            #1;
            send_psum(0, pix, pick_value(3, 0));
        end
        for (int pix = 0; pix < 20; pix++) begin
            @(posedge clk);
            #1;
            send_psum(1, pix, pick_value(3, 1));
        end
        idle_slot();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        psum_vld = 1'b1;
        psum_in  = DW'($urandom);
        #1;
        check_val("midrst_rd_en", 32'(buf_rd_en), 32'd0);
        check_val("midrst_rd_addr", 32'(buf_rd_addr), 32'd0);
        check_val("midrst_wr", {15'd0, buf_wr_en, buf_wr_data}, 32'd0);
        check_val("midrst_wr_addr", 32'(buf_wr_addr), 32'd0);
        check_val("midrst_ofm", {15'd0, ofm_vld, ofm_data}, 32'd0);
        check_val("midrst_busy_done_sat", {29'd0, busy, done, sat_flag}, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            psum_vld = 1'b1;
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        psum_vld = 1'b0;
        check_val("midrst_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        check_val("midrst_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        // Fresh pass after the abort restarts from channel 0.
        do_start();
        run_pass(3);
        wait_done();

        // Single channel, 2x2: psums pass straight through, no buffer access.
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk);
            #1;
            start2 = 1'b1;
            @(posedge clk);
            #1;
            start2 = 1'b0;
            check_val("nc1_busy_after_start", 32'(busy2), 32'd1);
            for (int pix = 0; pix < 4; pix++) begin
                @(posedge clk);
                #1;
                if (pass == 0) begin
                    case (pix)
                        0:       v2 = 16'hFFFB;
                        1:       v2 = 16'h7FFF;
                        2:       v2 = 16'h8000;
                        default: v2 = 16'h0001;
                    endcase
                end else begin
                    v2 = DW'($urandom);
                end
                start2    = (pix == 2);
                psum_vld2 = 1'b1;
                psum_in2  = v2;
                exp_ofm2_q.push_back({24'(cyc + 1), v2});
                if (pix == 3) exp_done2_cyc = cyc + 2;
            end
            for (int i = 0; i < 8 && !done2; i++) begin
                @(posedge clk);
                #1;
                start2    = 1'b0;
                psum_vld2 = 1'b0;
            end
            check_val("nc1_done_seen", 32'(done2), 32'd1);
            check_val("nc1_sat_flag", 32'(sat_flag2), 32'd0);
        end

        repeat (4) idle_slot();
        check_val("end_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
        check_val("end_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        check_val("end_ofm_q_empty", 32'(exp_ofm_q.size()), 32'd0);
        check_val("end_ofm2_q_empty", 32'(exp_ofm2_q.size()), 32'd0);
        check_val("end_no_pending_done", 32'(exp_done_cyc), 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/psum_accum_ctrl.md
# psum_accum_ctrl

Sequences the partial-sum accumulation buffer for one convolution layer pass. Streams row psums from the PE array. On the first input channel it stores them directly, and on middle channels it does a read-add-write into the buffer. On the last channel it emits the finished output-feature-map pixels instead of writing them back. It sits between the PE-array psum output and the OFM writer, alongside the psum enable sequencing.

## Interface
Parameters:
- DATA_WIDTH, 16: signed psum width.
- NUM_CHANNEL, 3: input channels accumulated per pass; must be ≥1.
- OFM_SIZE, 7: OFM width and height; must be ≥2. N = OFM_SIZE² pixels (49 by default).
- RELU, 1: if 1, the OFM output is clamped at 0.
- AW, $clog2(N) (6 by default): buffer address width.

Ports:
- clk, input, 1: the single clock; all logic is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: starts a pass; sampled only in IDLE.
- psum_vld, input, 1: psum_in is valid this cycle; there is no backpressure.
- psum_in, input, DATA_WIDTH: signed psum from the PE array, in raster pixel order.
- buf_rd_en, output, 1: buffer read request.
- buf_rd_addr, output, AW: buffer read address.
- buf_rd_data, input, DATA_WIDTH: buffer read data, valid 1 cycle after buf_rd_en.
- buf_wr_en, output, 1: buffer write strobe.
- buf_wr_addr, output, AW: buffer write address.
- buf_wr_data, output, DATA_WIDTH: buffer write data.
- ofm_vld, output, 1: ofm_data is valid this cycle.
- ofm_data, output, DATA_WIDTH: final pixel value.
- busy, output, 1: high from ACCUM through DONE.
- done, output, 1: one-cycle pulse at the end of a pass.
- sat_flag, output, 1: sticky flag, set on any saturation; cleared on accepted start.

## Operation
States:
- IDLE: waits for start.
- ACCUM: counts and accumulates incoming psums.
- DRAIN: flushes the stage-1 register.
- DONE: emits the done pulse.

Transitions:
- IDLE → ACCUM on start. Clears pix_cnt, ch_cnt and sat_flag.
- ACCUM → DRAIN when psum_vld is high with pix_cnt==N-1 and ch_cnt==NUM_CHANNEL-1.
- DRAIN → DONE unconditionally.
- DONE → IDLE unconditionally.

Counters:
- pix_cnt counts 0..N-1 and advances on each psum_vld in ACCUM.
- When pix_cnt wraps to 0, ch_cnt increments.
- psum_vld outside ACCUM is ignored: no counting, no buffer access.

Stage 0 (the psum_vld cycle in ACCUM):
- buf_rd_en = psum_vld & (ch_cnt≠0). This is combinational.
- buf_rd_addr = pix_cnt.
- The stage-1 register captures vld, addr, psum_in, first=(ch_cnt==0) and last=(ch_cnt==NUM_CHANNEL-1).

Stage 1 (the following cycle):
- sum = first ? s1_psum : sat_add(buf_rd_data, s1_psum).
- sat_add computes at DATA_WIDTH+1 bits, then clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- When a clamp occurs, sat_flag is set.
- Not last: buf_wr_en=1, buf_wr_addr=s1_addr, buf_wr_data=sum.
- Last: buf_wr_en=0, ofm_vld=1, ofm_data = RELU ? max(sum,0) : sum.
- When NUM_CHANNEL==1, first and last are both true: psum_in goes straight to the OFM output and the buffer is never accessed.

Hazard rules:
- A read and a write in the same cycle always target different addresses, because consecutive pixel indices differ and N≥2.
- The buffer is therefore not required to forward data.

Other rules:
- start while busy is ignored.
- Back-to-back passes are allowed: start may be asserted in the cycle after done.

## Timing
- Latency is 1 cycle: psum_vld at cycle t gives buf_wr_en or ofm_vld at cycle t+1.
- buf_rd_* outputs are combinational from stage-0 signals. buf_wr_* and ofm_* are driven from stage-1 registers plus the adder.
- Throughput is one psum per cycle with no bubbles. Gaps in psum_vld are allowed at any point.
- done is high for exactly 1 cycle, 2 cycles after the final psum: final psum at t, DRAIN at t+1, DONE (done=1) at t+2.
- busy is high from the cycle after start through the DONE cycle, inclusive.
- Reset values: state=IDLE, all counters 0, stage-1 vld=0, sat_flag=0, and every output 0.
- Reset asserted mid-pass aborts immediately with no buffer write. A later start begins from channel 0.

## Structure
- Shared package holds:
  - the state encoding (IDLE, ACCUM, DRAIN, DONE);
  - the N/AW localparam derivation;
  - the saturating-add function shared with the PE psum path.
- One sub-module: psum_sat_add.
  - Inputs: signed a, b, first.
  - Outputs: sum and sat.
  - Purely combinational; the FSM, counters and stage-1 register stay in the top.

## Test plan
- Defaults, 3 channels × 49 psums, all psum_in=10, continuous vld. Required:
  - channel 0 writes 10 to addresses 0..48 with no reads;
  - channel 1 reads and writes 20;
  - channel 2 gives 49 ofm_vld with ofm_data=30 and no writes;
  - done exactly 2 cycles after the 147th psum.
- Saturation: channel 0 = 0x7FF0, channel 1 = 0x0020. Required: buffer holds 0x7FFF, sat_flag=1 until the next start.
- RELU=1, final sum −5. Required: ofm_data=0. With RELU=0: ofm_data=0xFFFB.
- Random psum_vld gaps, including a gap at a channel boundary. Required: addresses stay contiguous, no duplicate or missing pixel, OFM matches the reference model.
- Reset asserted during channel 1 at pixel 20. Required: all outputs 0 next cycle. A following start reruns correctly from channel 0 with no stale writes.
- NUM_CHANNEL=1, OFM_SIZE=2. Required: 4 psums go out to ofm_data unchanged 1 cycle later, buf_rd_en and buf_wr_en never assert, and a start during busy is ignored.
